// File: rtl/mtimer_resp.sv
// Memory-mapped machine timer: 64-bit mtime/mtimecmp, control register and a
// registered level interrupt, answering loads combinationally like data memory.
module mtimer_resp #(
  parameter logic [31:0] BASE     = 32'h0000_F000,
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [2:0]  mem_type,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        timer_interupt
);

  localparam int unsigned PCNT_W = 16;
  localparam logic [2:0] MT_B  = 3'b000;
  localparam logic [2:0] MT_H  = 3'b001;
  localparam logic [2:0] MT_W  = 3'b010;
  localparam logic [2:0] MT_BU = 3'b100;
  localparam logic [2:0] MT_HU = 3'b101;
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PRESCALE - 1);

  logic [63:0]       mtime, mtime_next;
  logic [63:0]       mtimecmp, mtimecmp_next;
  logic              en, en_next, ie, ie_next;
  logic [PCNT_W-1:0] pcnt, pcnt_next;
  logic              irq_next;

  logic              sel;
  logic [2:0]        off;
  logic [1:0]        lane;
  logic [3:0]        be;
  logic [31:0]       wlane;
  logic [31:0]       cur_word;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic              tick;
  logic              wr_mt_lo, wr_mt_hi, wr_cmp_lo, wr_cmp_hi, wr_ctrl;

  assign sel  = (addr[31:5] == BASE[31:5]);
  assign off  = addr[4:2];
  assign lane = addr[1:0];
  assign tick = en && (pcnt == PCNT_LAST);

  // Replace the byte lanes enabled in be with the replicated store data.
  function automatic logic [31:0] merge(input logic [31:0] old_w,
                                        input logic [31:0] new_w,
                                        input logic [3:0]  lanes);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++)
      if (lanes[i]) res[8*i +: 8] = new_w[8*i +: 8];
    return res;
  endfunction

  // Store decode: byte enables and lane-replicated data; misaligned or unknown sizes write nothing.
  always_comb begin
    be    = 4'b0000;
    wlane = 32'h0;
    unique case (mem_type)
      MT_B: begin
        be    = 4'b0001 << lane;
        wlane = {4{wdata[7:0]}};
      end
      MT_H: begin
        if (!lane[0]) be = lane[1] ? 4'b1100 : 4'b0011;
        wlane = {2{wdata[15:0]}};
      end
      MT_W: begin
        if (lane == 2'b00) be = 4'b1111;
        wlane = wdata;
      end
      default: ;
    endcase
    if (!(wr_en && sel)) be = 4'b0000;
  end

  assign wr_mt_lo  = (|be) && (off == 3'd0);
  assign wr_mt_hi  = (|be) && (off == 3'd1);
  assign wr_cmp_lo = (|be) && (off == 3'd2);
  assign wr_cmp_hi = (|be) && (off == 3'd3);
  assign wr_ctrl   = (|be) && (off == 3'd4);

  // Next-state: a store to either mtime half suppresses that cycle's increment.
  always_comb begin
    mtime_next    = mtime;
    mtimecmp_next = mtimecmp;
    en_next       = en;
    ie_next       = ie;
    pcnt_next     = pcnt;
    if (wr_mt_lo || wr_mt_hi) begin
      if (wr_mt_lo) mtime_next[31:0]  = merge(mtime[31:0], wlane, be);
      if (wr_mt_hi) mtime_next[63:32] = merge(mtime[63:32], wlane, be);
    end else if (tick) begin
      mtime_next = mtime + 64'd1;
    end
    if (wr_cmp_lo) mtimecmp_next[31:0]  = merge(mtimecmp[31:0], wlane, be);
    if (wr_cmp_hi) mtimecmp_next[63:32] = merge(mtimecmp[63:32], wlane, be);
    if (wr_ctrl && be[0]) begin
      en_next = wlane[0];
      ie_next = wlane[1];
    end
    if (wr_ctrl || tick) pcnt_next = '0;
    else if (en)         pcnt_next = pcnt + PCNT_W'(1);
    irq_next = ie_next && (mtime_next >= mtimecmp_next);
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mtime          <= 64'h0;
      mtimecmp       <= 64'hFFFF_FFFF_FFFF_FFFF;
      en             <= 1'b0;
      ie             <= 1'b0;
      pcnt           <= '0;
      timer_interupt <= 1'b0;
    end else begin
      mtime          <= mtime_next;
      mtimecmp       <= mtimecmp_next;
      en             <= en_next;
      ie             <= ie_next;
      pcnt           <= pcnt_next;
      timer_interupt <= irq_next;
    end
  end

  // Current value of the addressed 32-bit register.
  always_comb begin
    cur_word = 32'h0;
    unique case (off)
      3'd0:    cur_word = mtime[31:0];
      3'd1:    cur_word = mtime[63:32];
      3'd2:    cur_word = mtimecmp[31:0];
      3'd3:    cur_word = mtimecmp[63:32];
      3'd4:    cur_word = {30'h0, ie, en};
      default: cur_word = 32'h0;
    endcase
  end

  // Load path: select and extend the addressed byte/half/word; misaligned reads return 0.
  always_comb begin
    rdata   = 32'h0;
    rd_byte = cur_word[{lane, 3'b000} +: 8];
    rd_half = lane[1] ? cur_word[31:16] : cur_word[15:0];
    if (rd_en && sel) begin
      unique case (mem_type)
        MT_B:  rdata = {{24{rd_byte[7]}}, rd_byte};
        MT_BU: rdata = {24'h0, rd_byte};
        MT_H:  if (!lane[0]) rdata = {{16{rd_half[15]}}, rd_half};
        MT_HU: if (!lane[0]) rdata = {16'h0, rd_half};
        MT_W:  if (lane == 2'b00) rdata = cur_word;
        default: rdata = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_mtimer_resp.sv
// Directed bench for mtimer_resp: byte-image reference model checked every cycle,
// plus literal expectations for the key scenarios, on PRESCALE=1 and PRESCALE=4 instances.
module tb_mtimer_resp;

  localparam logic [31:0] B = 32'h0000_F000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rd_en = 1'b0, wr_en = 1'b0;
  logic [2:0]  mem_type = 3'b010;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  logic [31:0] rdata1, rdata4;
  logic        irq1, irq4;

  int nerr = 0;
  int nchk = 0;

  always #5 clk = ~clk;

  mtimer_resp #(.BASE(B), .PRESCALE(1)) u_p1 (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .mem_type(mem_type),
    .addr(addr), .wdata(wdata), .rdata(rdata1), .timer_interupt(irq1));

  mtimer_resp #(.BASE(B), .PRESCALE(4)) u_p4 (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .mem_type(mem_type),
    .addr(addr), .wdata(wdata), .rdata(rdata4), .timer_interupt(irq4));

  // ---------------- reference model ----------------
  typedef struct {
    logic [63:0] mt;
    logic [63:0] cmp;
    logic        en;
    logic        ie;
    int          pcnt;
    logic        irq;
  } mstate_t;

  mstate_t m1, m4;

  function automatic mstate_t m_reset();
    mstate_t s;
    s.mt = 64'h0; s.cmp = '1; s.en = 1'b0; s.ie = 1'b0; s.pcnt = 0; s.irq = 1'b0;
    return s;
  endfunction

  function automatic bit in_win(logic [31:0] a);
    return a[31:5] == B[31:5];
  endfunction

  // Access size in bytes for a funct3 code (0 = not a valid access).
  function automatic int acc_size(logic [2:0] t, bit store);
    case (t)
      3'b000: return 1;
      3'b001: return 2;
      3'b010: return 4;
      3'b100: return store ? 0 : 1;
      3'b101: return store ? 0 : 2;
      default: return 0;
    endcase
  endfunction

  // The 32-byte window as software sees it, little-endian.
  function automatic logic [7:0] img_byte(mstate_t s, int i);
    if (i < 8)   return s.mt[8*i +: 8];
    if (i < 16)  return s.cmp[8*(i-8) +: 8];
    if (i == 16) return {6'b0, s.ie, s.en};
    return 8'h0;
  endfunction

  function automatic logic [31:0] m_load(mstate_t s, bit rd, logic [2:0] t, logic [31:0] a);
    int n;
    logic [31:0] v;
    if (!rd || !in_win(a)) return 32'h0;
    n = acc_size(t, 1'b0);
    if (n == 0 || (int'(a[4:0]) % n) != 0) return 32'h0;
    v = 32'h0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = img_byte(s, int'(a[4:0]) + i);
    if (t == 3'b000 && v[7])  v = v | 32'hFFFF_FF00;
    if (t == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  function automatic mstate_t m_step(mstate_t s, int presc, bit wr, logic [2:0] t,
                                     logic [31:0] a, logic [31:0] d);
    mstate_t ns;
    logic [7:0] img [32];
    bit written [32];
    bit tick, mt_w, ctrl_w;
    int n;
    for (int i = 0; i < 32; i++) begin
      img[i] = img_byte(s, i);
      written[i] = 1'b0;
    end
    n = acc_size(t, 1'b1);
    if (wr && in_win(a) && n != 0 && (int'(a[4:0]) % n) == 0)
      for (int i = 0; i < n; i++) begin
        img[int'(a[4:0]) + i] = d[8*i +: 8];
        written[int'(a[4:0]) + i] = 1'b1;
      end
    mt_w = 1'b0;
    for (int i = 0; i < 8; i++) mt_w |= written[i];
    ctrl_w = written[16] | written[17] | written[18] | written[19];
    tick = s.en && (s.pcnt == presc - 1);
    ns = s;
    for (int i = 0; i < 8; i++) begin
      ns.mt[8*i +: 8]  = img[i];
      ns.cmp[8*i +: 8] = img[8+i];
    end
    if (!mt_w && tick) ns.mt = s.mt + 64'd1;
    ns.en = img[16][0];
    ns.ie = img[16][1];
    if (ctrl_w || tick) ns.pcnt = 0;
    else if (s.en)      ns.pcnt = s.pcnt + 1;
    ns.irq = ns.ie && (ns.mt >= ns.cmp);
    return ns;
  endfunction

  // Model advances with the DUT; cleared asynchronously with it.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m1 = m_reset();
      m4 = m_reset();
    end else begin
      m1 = m_step(m1, 1, wr_en, mem_type, addr, wdata);
      m4 = m_step(m4, 4, wr_en, mem_type, addr, wdata);
    end
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      check("model_rdata_p1", rdata1, m_load(m1, rd_en, mem_type, addr));
      check("model_rdata_p4", rdata4, m_load(m4, rd_en, mem_type, addr));
      check("model_irq_p1", {31'h0, irq1}, {31'h0, m1.irq});
      check("model_irq_p4", {31'h0, irq4}, {31'h0, m4.irq});
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic st(logic [2:0] t, logic [31:0] a, logic [31:0] d);
    wr_en = 1'b1; mem_type = t; addr = a; wdata = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic ld(string name, logic [2:0] t, logic [31:0] a, bit p4, logic [31:0] exp);
    rd_en = 1'b1; mem_type = t; addr = a;
    @(negedge clk);
    check(name, p4 ? rdata4 : rdata1, exp);
    @(posedge clk); #1;
    rd_en = 1'b0;
  endtask

  initial begin
    #3;
    check("irq_in_reset", {31'h0, irq1}, 32'h0);
    #9 rst = 1'b1;
    @(posedge clk); #1;

    // reset values
    ld("rst_cmp_lo", 3'b010, B + 32'h08, 1'b0, 32'hFFFF_FFFF);
    ld("rst_mtime_lo", 3'b010, B + 32'h00, 1'b0, 32'h0);
    ld("rst_ctrl", 3'b010, B + 32'h10, 1'b0, 32'h0);
    check("rst_irq", {31'h0, irq1}, 32'h0);

    // count and carry, PRESCALE=1
    st(3'b010, B + 32'h00, 32'hFFFF_FFFE);
    st(3'b010, B + 32'h04, 32'h0);
    st(3'b010, B + 32'h10, 32'h1);
    idle(2);
    ld("carry_hi", 3'b010, B + 32'h04, 1'b0, 32'h1);
    ld("carry_lo", 3'b010, B + 32'h00, 1'b0, 32'h1);

    // prescale by 4
    st(3'b010, B + 32'h10, 32'h0);
    st(3'b010, B + 32'h00, 32'h0);
    st(3'b010, B + 32'h04, 32'h0);
    st(3'b010, B + 32'h10, 32'h1);
    idle(12);
    ld("presc_count", 3'b010, B + 32'h00, 1'b1, 32'h3);
    st(3'b010, B + 32'h10, 32'h0);
    idle(10);
    ld("presc_hold", 3'b010, B + 32'h00, 1'b1, 32'h3);

    // interrupt
    st(3'b010, B + 32'h08, 32'hFFFF_FFFF);
    st(3'b010, B + 32'h0C, 32'h0);
    st(3'b010, B + 32'h08, 32'd10);
    st(3'b010, B + 32'h00, 32'h0);
    st(3'b010, B + 32'h04, 32'h0);
    st(3'b010, B + 32'h10, 32'h3);
    idle(9);
    check("irq_before", {31'h0, irq1}, 32'h0);
    idle(1);
    check("irq_rise", {31'h0, irq1}, 32'h1);
    st(3'b010, B + 32'h08, 32'd100);
    check("irq_clear", {31'h0, irq1}, 32'h0);

    // sub-word access, counting stopped
    st(3'b010, B + 32'h10, 32'h0);
    st(3'b010, B + 32'h00, 32'h0);
    st(3'b000, B + 32'h12, 32'hFF);
    ld("sb_ctrl_hi", 3'b010, B + 32'h10, 1'b0, 32'h0);
    st(3'b000, B + 32'h01, 32'h80);
    ld("lb_sext", 3'b000, B + 32'h01, 1'b0, 32'hFFFF_FF80);
    ld("lbu_zext", 3'b100, B + 32'h01, 1'b0, 32'h0000_0080);
    st(3'b010, B + 32'h02, 32'hDEAD_BEEF);
    ld("sw_misaligned", 3'b010, B + 32'h00, 1'b0, 32'h0000_8000);
    ld("lh_misaligned", 3'b001, B + 32'h03, 1'b0, 32'h0);
    ld("lh_sext", 3'b001, B + 32'h00, 1'b0, 32'hFFFF_8000);
    ld("lhu_zext", 3'b101, B + 32'h00, 1'b0, 32'h0000_8000);
    ld("unused_reg", 3'b010, B + 32'h14, 1'b0, 32'h0);

    // window edge and collisions
    ld("outside_win", 3'b010, B + 32'h20, 1'b0, 32'h0);
    st(3'b010, B + 32'h10, 32'h1);
    st(3'b010, B + 32'h00, 32'd5);
    ld("wr_beats_tick", 3'b010, B + 32'h00, 1'b0, 32'd5);
    rd_en = 1'b1; wr_en = 1'b1; mem_type = 3'b010; addr = B + 32'h08; wdata = 32'd7;
    @(negedge clk);
    check("rdwr_old_val", rdata1, 32'd100);
    @(posedge clk); #1;
    rd_en = 1'b0; wr_en = 1'b0;
    ld("rdwr_new_val", 3'b010, B + 32'h08, 1'b0, 32'd7);

    // asynchronous reset mid-operation
    st(3'b010, B + 32'h08, 32'h0);
    st(3'b010, B + 32'h10, 32'h3);
    check("irq_set_pre_rst", {31'h0, irq1}, 32'h1);
    rd_en = 1'b1; mem_type = 3'b010; addr = B + 32'h08;
    #2 rst = 1'b0;
    #1;
    check("irq_async_rst", {31'h0, irq1}, 32'h0);
    check("cmp_async_rst", rdata1, 32'hFFFF_FFFF);
    rd_en = 1'b0;
    @(posedge clk); #3 rst = 1'b1;
    idle(2);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
